// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for bram_arbiter: FSM and port-select encodings, byte-enable expansion.
// Used by both the default build and the BRAM_ARB_CLEAR_EN build.
package bram_arbiter_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned MAX_BE_W   = 64;
  localparam int unsigned MAX_DATA_W = MAX_BE_W * 8;

  // A set bit in the result means the RAM keeps its old bit.
  function automatic logic [MAX_DATA_W-1:0] be_to_mask(input logic [MAX_BE_W-1:0] be);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BE_W; i++) m[8*i +: 8] = {8{~be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/bram_arbiter_arb_rr2.sv
// Two-way arbiter, A = req[0], B = req[1]; combinational grant, pointer remembers the last winner.
module arb_rr2
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        if ((ROUND_ROBIN != 0) && (last_q == PORT_A)) gnt = 2'b10;
        else                                         gnt = 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Reset to B so that A wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_q <= PORT_B;
    else if (gnt != 2'b00) last_q <= gnt[1];
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester block-RAM controller: one operation per cycle, read responses routed by tag.
// BRAM_ARB_CLEAR_EN adds a zero-fill sweep of the whole RAM after every reset.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                a_req_i,
  input  logic                a_we_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  input  logic [DATA_W/8-1:0] a_be_i,
  output logic                a_gnt_o,
  output logic                a_rvalid_o,
  output logic [DATA_W-1:0]   a_rdata_o,
  input  logic                b_req_i,
  input  logic                b_we_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  input  logic [DATA_W/8-1:0] b_be_i,
  output logic                b_gnt_o,
  output logic                b_rvalid_o,
  output logic [DATA_W-1:0]   b_rdata_o,
  output logic                init_done_o,
  output logic [ADDR_W-1:0]   bram_raddr_o,
  output logic                bram_read_en_o,
  output logic [ADDR_W-1:0]   bram_waddr_o,
  output logic [DATA_W-1:0]   bram_wdata_o,
  output logic [DATA_W-1:0]   bram_wmask_o,
  output logic                bram_write_en_o,
  input  logic [DATA_W-1:0]   bram_rdata_i
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic              run;
  logic              clearing;
  logic [ADDR_W-1:0] clear_addr;

`ifdef BRAM_ARB_CLEAR_EN
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_INIT) && (cnt_q == CNT_LAST)) state_d = ST_RUN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   cnt_q <= '0;
    else if (state_q == ST_INIT) cnt_q <= cnt_q + ADDR_W'(1);
  end

  assign run         = (state_q == ST_RUN);
  assign clearing    = ~run;
  assign clear_addr  = cnt_q;
  assign init_done_o = run;
`else
  assign run         = 1'b1;
  assign clearing    = 1'b0;
  assign clear_addr  = '0;
  assign init_done_o = 1'b1;
`endif

  logic [1:0] gnt;

  arb_rr2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .en  (run),
    .req ({b_req_i, a_req_i}),
    .gnt (gnt)
  );

  assign a_gnt_o = gnt[0];
  assign b_gnt_o = gnt[1];

  // Payload of whichever port won this cycle.
  logic              sel_b;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [BE_W-1:0]   op_be;
  logic [DATA_W-1:0] op_mask;

  assign sel_b    = gnt[1];
  assign op_we    = sel_b ? b_we_i    : a_we_i;
  assign op_addr  = sel_b ? b_addr_i  : a_addr_i;
  assign op_wdata = sel_b ? b_wdata_i : a_wdata_i;
  assign op_be    = sel_b ? b_be_i    : a_be_i;
  assign op_mask  = DATA_W'(be_to_mask(MAX_BE_W'(op_be)));

  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q, wmask_q;

  always_comb begin
    bram_read_en_o  = 1'b0;
    bram_write_en_o = 1'b0;
    bram_raddr_o    = raddr_q;
    bram_waddr_o    = waddr_q;
    bram_wdata_o    = wdata_q;
    bram_wmask_o    = wmask_q;
    if (clearing) begin
      bram_write_en_o = 1'b1;
      bram_waddr_o    = clear_addr;
      bram_wdata_o    = '0;
      bram_wmask_o    = '0;
    end else if (gnt != 2'b00) begin
      if (op_we) begin
        bram_write_en_o = 1'b1;
        bram_waddr_o    = op_addr;
        bram_wdata_o    = op_wdata;
        bram_wmask_o    = op_mask;
      end else begin
        bram_read_en_o  = 1'b1;
        bram_raddr_o    = op_addr;
      end
    end
  end

  // Idle cycles keep presenting the last address and data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      raddr_q <= bram_raddr_o;
      waddr_q <= bram_waddr_o;
      wdata_q <= bram_wdata_o;
      wmask_q <= bram_wmask_o;
    end
  end

  // Response tag: the read issued this cycle returns on the granted port next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_rvalid_o <= 1'b0;
      b_rvalid_o <= 1'b0;
    end else begin
      a_rvalid_o <= bram_read_en_o & (sel_b == PORT_A);
      b_rvalid_o <= bram_read_en_o & (sel_b == PORT_B);
    end
  end

  assign a_rdata_o = bram_rdata_i;
  assign b_rdata_o = bram_rdata_i;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural RAM; a second instance covers fixed priority.
// Build with BRAM_ARB_CLEAR_EN defined to also exercise the zero-fill sweep.
module tb_bram_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_be, b_be;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
  logic [31:0] a_rdata, b_rdata;
  logic [7:0]  bram_raddr, bram_waddr;
  logic        bram_read_en, bram_write_en;
  logic [31:0] bram_wdata, bram_wmask, bram_rdata;

  logic        f_a_req, f_b_req;
  logic        f_a_gnt, f_a_rvalid, f_b_gnt, f_b_rvalid, f_init_done;
  logic [31:0] f_a_rdata, f_b_rdata;
  logic [7:0]  f_raddr, f_waddr;
  logic        f_read_en, f_write_en;
  logic [31:0] f_wdata, f_wmask;

  int errors = 0;
  int checks = 0;

  bram_arbiter #(.ADDR_W(8), .DATA_W(32), .ROUND_ROBIN(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_be_i(a_be),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_be_i(b_be),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .init_done_o(init_done),
    .bram_raddr_o(bram_raddr), .bram_read_en_o(bram_read_en),
    .bram_waddr_o(bram_waddr), .bram_wdata_o(bram_wdata), .bram_wmask_o(bram_wmask),
    .bram_write_en_o(bram_write_en), .bram_rdata_i(bram_rdata)
  );

  bram_arbiter #(.ADDR_W(8), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(f_a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_be_i(a_be),
    .a_gnt_o(f_a_gnt), .a_rvalid_o(f_a_rvalid), .a_rdata_o(f_a_rdata),
    .b_req_i(f_b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_be_i(b_be),
    .b_gnt_o(f_b_gnt), .b_rvalid_o(f_b_rvalid), .b_rdata_o(f_b_rdata),
    .init_done_o(f_init_done),
    .bram_raddr_o(f_raddr), .bram_read_en_o(f_read_en),
    .bram_waddr_o(f_waddr), .bram_wdata_o(f_wdata), .bram_wmask_o(f_wmask),
    .bram_write_en_o(f_write_en), .bram_rdata_i(bram_rdata)
  );

  // Behavioural 32x256 RAM: masked write, one-cycle registered read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bram_write_en) mem[bram_waddr] <= (mem[bram_waddr] & bram_wmask) | (bram_wdata & ~bram_wmask);
    if (bram_read_en)  bram_rdata <= mem[bram_raddr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    f_a_req = 0; f_b_req = 0;
  endtask

  // Called at the negedge right after reset release; skipped = cycles already elapsed.
  task automatic wait_init(input int skipped);
`ifdef BRAM_ARB_CLEAR_EN
    int n = 0;
    int nw = 0;
    int gseen = 0;
    logic [7:0] exp_addr;
    while (!init_done && n < 1000) begin
      exp_addr = 8'(n + skipped);
      if (bram_write_en && bram_wmask == 32'h0 && bram_wdata == 32'h0 && bram_waddr == exp_addr) nw++;
      if (a_gnt || b_gnt) gseen++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 256 - skipped) begin errors++; $display("FAIL init_cycles: got %0d expected %0d", n, 256 - skipped); end
    checks++;
    if (nw != 256 - skipped) begin errors++; $display("FAIL init_writes: got %0d expected %0d", nw, 256 - skipped); end
    checks++;
    if (gseen != 0) begin errors++; $display("FAIL init_gnt: got %0d grants expected 0", gseen); end
`else
    if (skipped < 0) $display("skipped=%0d", skipped);
`endif
  endtask

  task automatic test_reset;
    logic exp_done_rst;
`ifdef BRAM_ARB_CLEAR_EN
    exp_done_rst = 1'b0;
`else
    exp_done_rst = 1'b1;
`endif
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid: got a=%b b=%b expected 0 0", a_rvalid, b_rvalid);
    end
    checks++;
    if (init_done !== exp_done_rst) begin
      errors++; $display("FAIL reset_init_done: got %b expected %b", init_done, exp_done_rst);
    end
    rst = 0;
    #1;
    wait_init(0);
    checks++;
    if (init_done !== 1'b1 || a_gnt !== 1'b0 || b_gnt !== 1'b0 || bram_read_en !== 1'b0 || bram_write_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got done=%b gnt=%b%b re=%b we=%b expected 1 00 0 0",
                         init_done, a_gnt, b_gnt, bram_read_en, bram_write_en);
    end
  endtask

  task automatic test_partial_write;
    @(negedge clk);
    b_req = 1; b_we = 1; b_addr = 8'h05; b_wdata = 32'h11223344; b_be = 4'b1111; #1;
    checks++;
    if (b_gnt !== 1'b1 || bram_write_en !== 1'b1 || bram_wmask !== 32'h0 || bram_waddr !== 8'h05) begin
      errors++; $display("FAIL pw_full_write: got gnt=%b we=%b mask=%h addr=%h expected 1 1 00000000 05",
                         b_gnt, bram_write_en, bram_wmask, bram_waddr);
    end
    @(negedge clk);
    b_wdata = 32'hAABBCCDD; b_be = 4'b0101; #1;
    checks++;
    if (bram_wmask !== 32'hFF00FF00 || bram_write_en !== 1'b1 || bram_wdata !== 32'hAABBCCDD) begin
      errors++; $display("FAIL pw_mask: got mask=%h we=%b data=%h expected FF00FF00 1 AABBCCDD",
                         bram_wmask, bram_write_en, bram_wdata);
    end
    @(negedge clk);
    b_we = 0; #1;
    checks++;
    if (b_gnt !== 1'b1 || bram_read_en !== 1'b1 || bram_write_en !== 1'b0 || bram_raddr !== 8'h05) begin
      errors++; $display("FAIL pw_read_issue: got gnt=%b re=%b we=%b raddr=%h expected 1 1 0 05",
                         b_gnt, bram_read_en, bram_write_en, bram_raddr);
    end
    @(posedge clk); #1;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h11BB33DD || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL pw_read_data: got b_rvalid=%b data=%h a_rvalid=%b expected 1 11BB33DD 0",
                         b_rvalid, b_rdata, a_rvalid);
    end
    @(negedge clk);
    b_req = 0; #1;
    checks++;
    if (bram_read_en !== 1'b0 || bram_write_en !== 1'b0) begin
      errors++; $display("FAIL pw_idle: got re=%b we=%b expected 0 0", bram_read_en, bram_write_en);
    end
    @(posedge clk); #1;
    checks++;
    if (b_rvalid !== 1'b0) begin errors++; $display("FAIL pw_rvalid_pulse: got %b expected 0", b_rvalid); end
  endtask

  task automatic test_be_zero;
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 8'h05; a_wdata = 32'hFFFFFFFF; a_be = 4'b0000; #1;
    checks++;
    if (a_gnt !== 1'b1 || bram_write_en !== 1'b1 || bram_wmask !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL be0_write: got gnt=%b we=%b mask=%h expected 1 1 FFFFFFFF",
                         a_gnt, bram_write_en, bram_wmask);
    end
    @(negedge clk);
    a_we = 0; #1;
    @(posedge clk); #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h11BB33DD) begin
      errors++; $display("FAIL be0_unchanged: got rvalid=%b data=%h expected 1 11BB33DD", a_rvalid, a_rdata);
    end
    @(negedge clk);
    a_req = 0;
  endtask

  task automatic test_read_after_write;
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 8'hFF; a_wdata = 32'h00000042; a_be = 4'b1111; #1;
    checks++;
    if (a_gnt !== 1'b1 || bram_write_en !== 1'b1 || bram_waddr !== 8'hFF) begin
      errors++; $display("FAIL raw_write: got gnt=%b we=%b waddr=%h expected 1 1 FF", a_gnt, bram_write_en, bram_waddr);
    end
    @(posedge clk); #1;
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL raw_no_rvalid_on_write: got a=%b b=%b expected 0 0", a_rvalid, b_rvalid);
    end
    @(negedge clk);
    a_req = 0; a_we = 0;
    b_req = 1; b_we = 0; b_addr = 8'hFF; #1;
    checks++;
    if (b_gnt !== 1'b1 || bram_read_en !== 1'b1 || bram_raddr !== 8'hFF) begin
      errors++; $display("FAIL raw_read: got gnt=%b re=%b raddr=%h expected 1 1 FF", b_gnt, bram_read_en, bram_raddr);
    end
    @(posedge clk); #1;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h00000042 || a_rvalid !== 1'b0) begin
      errors++; $display("FAIL raw_data: got b_rvalid=%b data=%h a_rvalid=%b expected 1 00000042 0",
                         b_rvalid, b_rdata, a_rvalid);
    end
    @(negedge clk);
    b_req = 0;
  endtask

  // Last grant before this test went to B, so A wins the first conflict.
  task automatic test_round_robin;
    logic exp_a;
    a_we = 0; b_we = 0; a_addr = 8'h05; b_addr = 8'h05;
    for (int i = 0; i < 6; i++) begin
      exp_a = ((i % 2) == 0);
      @(negedge clk);
      a_req = 1; b_req = 1; #1;
      checks++;
      if (a_gnt !== exp_a || b_gnt !== ~exp_a) begin
        errors++; $display("FAIL rr_gnt[%0d]: got a=%b b=%b expected %b %b", i, a_gnt, b_gnt, exp_a, ~exp_a);
      end
      @(posedge clk); #1;
      checks++;
      if (a_rvalid !== exp_a || b_rvalid !== ~exp_a) begin
        errors++; $display("FAIL rr_rvalid[%0d]: got a=%b b=%b expected %b %b", i, a_rvalid, b_rvalid, exp_a, ~exp_a);
      end
      checks++;
      if ((exp_a ? a_rdata : b_rdata) !== 32'h11BB33DD) begin
        errors++; $display("FAIL rr_rdata[%0d]: got %h expected 11BB33DD", i, exp_a ? a_rdata : b_rdata);
      end
    end
    @(negedge clk);
    a_req = 0; b_req = 0;
  endtask

  task automatic test_fixed_priority;
    a_we = 0; b_we = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      f_a_req = 1; f_b_req = 1; #1;
      checks++;
      if (f_a_gnt !== 1'b1 || f_b_gnt !== 1'b0) begin
        errors++; $display("FAIL fp_gnt[%0d]: got a=%b b=%b expected 1 0", i, f_a_gnt, f_b_gnt);
      end
      @(posedge clk); #1;
      checks++;
      if (f_a_rvalid !== 1'b1 || f_b_rvalid !== 1'b0) begin
        errors++; $display("FAIL fp_rvalid[%0d]: got a=%b b=%b expected 1 0", i, f_a_rvalid, f_b_rvalid);
      end
    end
    @(negedge clk);
    f_a_req = 0; #1;
    checks++;
    if (f_b_gnt !== 1'b1 || f_a_gnt !== 1'b0) begin
      errors++; $display("FAIL fp_b_after_a: got a=%b b=%b expected 0 1", f_a_gnt, f_b_gnt);
    end
    @(negedge clk);
    f_b_req = 0;
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 8'h05; #1;
    checks++;
    if (a_gnt !== 1'b1 || bram_read_en !== 1'b1) begin
      errors++; $display("FAIL mid_issue: got gnt=%b re=%b expected 1 1", a_gnt, bram_read_en);
    end
    @(posedge clk); #1;
    checks++;
    if (a_rvalid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b expected 1", a_rvalid); end
    #1 rst = 1;
    a_req = 0;
    #1;
    checks++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear: got a=%b b=%b expected 0 0", a_rvalid, b_rvalid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0; #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse[%0d]: got %b expected 0", i, a_rvalid); end
    end
    @(negedge clk);
    wait_init(3);
  endtask

`ifdef BRAM_ARB_CLEAR_EN
  task automatic test_clear;
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF; a_be = 4'b1111; #1;
    checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL clr_preload: got gnt=%b expected 1", a_gnt); end
    @(negedge clk);
    a_req = 0; a_we = 0;
    rst = 1;
    @(negedge clk);
    a_req = 1; a_addr = 8'h10;
    rst = 0; #1;
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL clr_done_low: got %b expected 0", init_done); end
    wait_init(0);
    checks++;
    if (a_gnt !== 1'b1 || bram_read_en !== 1'b1 || bram_raddr !== 8'h10) begin
      errors++; $display("FAIL clr_first_run: got gnt=%b re=%b raddr=%h expected 1 1 10", a_gnt, bram_read_en, bram_raddr);
    end
    @(posedge clk); #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h00000000) begin
      errors++; $display("FAIL clr_read_zero: got rvalid=%b data=%h expected 1 00000000", a_rvalid, a_rdata);
    end
    @(negedge clk);
    a_req = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_partial_write();
    test_be_zero();
    test_read_after_write();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid_read();
`ifdef BRAM_ARB_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
